// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline stage registers.
// Holds the stage-register state encoding, per-stage payload widths and the
// packed payload layouts carried between ID/EX, EX/MEM and MEM/WB.
package pipe_pkg;

  // Occupancy of a stage register: TWO is reachable only in skid mode.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam int unsigned ID_EX_W  = 5 * XLEN + 3 * REG_W;  // 175
  localparam int unsigned EX_MEM_W = 3 * XLEN + REG_W + 4;  // 105
  localparam int unsigned MEM_WB_W = XLEN + REG_W + 2;      // 39

  // Decode -> execute payload.
  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } id_ex_t;

  // Execute -> memory payload.
  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [XLEN-1:0]  pc_plus4;
    logic [REG_W-1:0] rd;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
  } ex_mem_t;

  // Memory -> writeback payload.
  typedef struct packed {
    logic [XLEN-1:0]  wb_data;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             wb_valid;
  } mem_wb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stall-cycle performance counting.
// Ports: clk, rst (async active-high), inc (count enable), cnt (value).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Count up on inc, hold once all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and a saturating stall-cycle counter.
// Optional feature: define PIPE_SKID_EN for a two-entry (main + skid) variant
// whose in_ready comes straight from a flop; otherwise a single entry with
// in_ready = !out_valid | out_ready.
// Ports: clk, rst (async active-high), flush, in_valid/in_ready/in_data
// (upstream), out_valid/out_ready/out_data (downstream), stall_cnt.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = ID_EX_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q;
  logic [DATA_W-1:0] main_q;
  logic              in_fire;
  logic              out_fire;

  // main_q is zeroed whenever the stage empties, so a bubble reads as zero.
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
  pipe_state_e       state_d;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;

  assign in_ready = in_ready_q;

  // Next occupancy; flush overrides every handshake event.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_ready)      state_d = TWO;
          else if (!in_fire && out_fire)  state_d = EMPTY;
        end
        TWO:     if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, payload registers and the registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (flush) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        case (state_q)
          EMPTY: if (in_fire) main_q <= in_data;
          ONE: begin
            if (in_fire && out_fire) main_q <= in_data;
            else if (in_fire)        skid_q <= in_data;
            else if (out_fire)       main_q <= '0;
          end
          TWO: begin
            if (out_fire) begin
              main_q <= skid_q;
              skid_q <= '0;
            end
          end
          default: begin
            main_q <= '0;
            skid_q <= '0;
          end
        endcase
      end
    end
  end
`else
  // Legacy timing: accept when empty or when the held entry leaves this cycle.
  assign in_ready = ~out_valid | out_ready;

  // Single-entry state and payload; in ONE an in_fire implies out_fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            main_q  <= in_data;
          end
        end
        ONE: begin
          if (in_fire) begin
            main_q <= in_data;
          end else if (out_fire) begin
            state_q <= EMPTY;
            main_q  <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          main_q  <= '0;
        end
      endcase
    end
  end
`endif

  // Stall cycles: held payload not taken downstream; flush does not clear it.
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          f;
    logic          iv;
    logic [DW-1:0] d;
    logic          orr;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [CW-1:0] e_st;
  } vec_t;

  pipe_stage_reg #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, check outputs before the rising edge.
  task automatic cyc(input string name, input logic f, input logic iv, input logic [DW-1:0] d,
                     input logic orr, input logic e_ov, input logic [DW-1:0] e_od,
                     input logic e_ir, input logic [CW-1:0] e_st);
    @(negedge clk);
    flush = f; in_valid = iv; in_data = d; out_ready = orr;
    #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    check({name, ".out_data"},  32'(out_data),  32'(e_od));
    check({name, ".in_ready"},  32'(in_ready),  32'(e_ir));
    check({name, ".stall_cnt"}, 32'(stall_cnt), 32'(e_st));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vec_t          vecs[9];
    logic [DW-1:0] q[$];
    int            m_stall;
    logic          m_ir;
    logic          m_ov;
    logic [DW-1:0] m_od;

    // Streaming 1,2,3 then flush of an incoming 7 while holding 5.
    vecs[0] = '{1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 1'b1, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 16'd2, 1'b1, 4'd0};
    vecs[3] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd3, 1'b1, 4'd0};
    vecs[4] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0};
    vecs[5] = '{1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0};
    vecs[6] = '{1'b1, 1'b1, 16'd7, 1'b1, 1'b1, 16'd5, 1'b1, 4'd0};
    vecs[7] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0};
    vecs[8] = '{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_data",  32'(out_data),  32'd0);
    check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    do_reset();

    foreach (vecs[i])
      cyc($sformatf("vec%0d", i), vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].orr,
          vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir, vecs[i].e_st);

    // Back-pressure: 1 and 2 sent while downstream stalls, then drained in order.
    do_reset();
    if (SKID) begin
      cyc("bp_a", 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0);
      cyc("bp_b", 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 1'b1, 4'd0);
      cyc("bp_c", 1'b0, 1'b1, 16'd9, 1'b0, 1'b1, 16'd1, 1'b0, 4'd1);
      cyc("bp_d", 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd1, 1'b0, 4'd2);
      cyc("bp_e", 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 1'b1, 4'd2);
      cyc("bp_f", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd2);
    end else begin
      cyc("bp_a", 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 1'b1, 4'd0);
      cyc("bp_b", 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 1'b0, 4'd0);
      cyc("bp_c", 1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 1'b0, 4'd1);
      cyc("bp_d", 1'b0, 1'b1, 16'd2, 1'b1, 1'b1, 16'd1, 1'b1, 4'd2);
      cyc("bp_e", 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 16'd2, 1'b1, 4'd2);
      cyc("bp_f", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd2);
    end

    // Flush and stall in the same cycle: flush empties, counter still counts.
    do_reset();
    cyc("fs_load",  1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0);
    cyc("fs_flush", 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 16'd5, SKID, 4'd0);
    cyc("fs_after", 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 1'b1, 4'd1);

    // Saturation: 20 stalled cycles, counter stops at 15.
    do_reset();
    cyc("sat_load", 1'b0, 1'b1, 16'hA5A5, 1'b1, 1'b0, 16'd0, 1'b1, 4'd0);
    for (int k = 0; k < 20; k++)
      cyc($sformatf("sat%0d", k), 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'hA5A5, SKID,
          CW'((k > 15) ? 15 : k));
    cyc("sat_end", 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'hA5A5, SKID, 4'd15);

    // Asynchronous reset while holding 0xA5A5: outputs clear before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.out_data",  32'(out_data),  32'd0);
    check("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Randomized run against a FIFO-occupancy model of the stage.
    do_reset();
    q.delete();
    m_stall = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      flush     = ($urandom_range(0, 99) < 5);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      #1;
      m_ov = (q.size() != 0);
      m_od = m_ov ? q[0] : '0;
      m_ir = SKID ? (q.size() < 2) : (!m_ov || out_ready);
      check($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(m_ov));
      check($sformatf("rnd%0d.out_data", c),  32'(out_data),  32'(m_od));
      check($sformatf("rnd%0d.in_ready", c),  32'(in_ready),  32'(m_ir));
      check($sformatf("rnd%0d.stall_cnt", c), 32'(stall_cnt), 32'(m_stall));
      if (m_ov && !out_ready && m_stall < 15) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) q.push_back(in_data);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
